imem_boot_loader: RTL

//  Serial program loader upstream of processor_top. Accepts a byte stream
//  (valid/ready), assembles 16-bit instruction words, writes them

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the byte source / memory model uses master.
interface imem_boot_loader_if #(
  parameter int PROG_CTR_WID = 10
) ();
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic                    imem_wr_en;
  logic [PROG_CTR_WID-1:0] imem_wr_addr;
  logic [15:0]             imem_wr_data;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Serial program loader: assembles 16-bit words from a byte frame, writes them to
// instruction memory, verifies an XOR checksum and releases cpu_reset on success.
module imem_boot_loader #(
  parameter int PROG_CTR_WID = 10
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  input  logic                reload,
  output logic                cpu_reset,
  output logic                load_done,
  output logic                load_err
);

  localparam logic [16:0] DEPTH = 17'(2**PROG_CTR_WID);

  typedef enum logic [2:0] {
    S_CNT_HI, S_CNT_LO, S_INS_HI, S_INS_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t                  state, state_next;
  logic                    xfer;
  logic                    last_word;
  logic [15:0]             n_word;
  logic [15:0]             cnt;
  logic [7:0]              cnt_hi;
  logic [7:0]              ins_hi;
  logic [7:0]              xor_acc;
  logic [PROG_CTR_WID-1:0] addr_cnt;
  logic                    wr_en_p1;
  logic [PROG_CTR_WID-1:0] wr_addr_p1;
  logic [15:0]             wr_data_p1;

  // A reload cycle refuses the byte so the restart never swallows frame data.
  assign bus.rx_ready = (state != S_DONE) && (state != S_ERR) && !reload;
  assign xfer         = bus.rx_valid && bus.rx_ready;
  assign n_word       = {cnt_hi, bus.rx_data};
  assign last_word    = ((17'(addr_cnt) + 17'd1) == 17'(cnt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CNT_HI;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (reload) begin
      state_next = S_CNT_HI;
    end else if (xfer) begin
      case (state)
        S_CNT_HI: state_next = S_CNT_LO;
        S_CNT_LO: begin
          if (n_word == 16'd0)              state_next = S_CHK;
          else if ({1'b0, n_word} > DEPTH)  state_next = S_ERR;
          else                              state_next = S_INS_HI;
        end
        S_INS_HI: state_next = S_INS_LO;
        S_INS_LO: state_next = last_word ? S_CHK : S_INS_HI;
        S_CHK:    state_next = (bus.rx_data == xor_acc) ? S_DONE : S_ERR;
        default:  state_next = state;
      endcase
    end
  end

  // Stage p1: registered memory write and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xor_acc    <= 8'd0;
      cnt        <= 16'd0;
      addr_cnt   <= '0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= 16'd0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      wr_en_p1 <= 1'b0;
      if (reload) begin
        xor_acc  <= 8'd0;
        cnt      <= 16'd0;
        addr_cnt <= '0;
      end else if (xfer) begin
        if (state != S_CHK) xor_acc <= xor_acc ^ bus.rx_data;
        if (state == S_CNT_LO) cnt <= n_word;
        if (state == S_INS_LO) begin
          wr_en_p1   <= 1'b1;
          wr_addr_p1 <= addr_cnt;
          wr_data_p1 <= {ins_hi, bus.rx_data};
          // Hold at the final address so a full-depth image never wraps to 0.
          if (!last_word) addr_cnt <= addr_cnt + 1'b1;
        end
      end
      cpu_reset <= reload || (state != S_DONE);
      load_done <= (state_next == S_DONE);
      load_err  <= (state_next == S_ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && (state == S_CNT_HI)) cnt_hi <= bus.rx_data;
    if (xfer && (state == S_INS_HI)) ins_hi <= bus.rx_data;
  end

  assign bus.imem_wr_en   = wr_en_p1;
  assign bus.imem_wr_addr = wr_addr_p1;
  assign bus.imem_wr_data = wr_data_p1;

endmodule
